// File: rtl/cp0_intc_if.sv
// Pipeline-side bundle for the coprocessor-0 / interrupt controller.
// The pipeline (master) drives MEM-stage requests; cp0_intc (slave) answers with data and redirects.
interface cp0_intc_if #(
    parameter int unsigned N_INT = 2
);
    logic [N_INT-1:0] irq_in;
    logic             stall;
    logic [1:0]       operation;
    logic [4:0]       read_addr;
    logic [31:0]      read_data;
    logic [4:0]       write_addr;
    logic [31:0]      write_data;
    logic             undefined;
    logic             overflow;
    logic             out_of_range;
    logic [31:0]      epc_in;
    logic             flush;
    logic             jump_en;
    logic [31:0]      jump_addr;
    logic [N_INT-1:0] int_pending;
    logic             in_handler;

    modport master (
        output irq_in, stall, operation, read_addr, write_addr, write_data,
               undefined, overflow, out_of_range, epc_in,
        input  read_data, flush, jump_en, jump_addr, int_pending, in_handler
    );

    modport slave (
        input  irq_in, stall, operation, read_addr, write_addr, write_data,
               undefined, overflow, out_of_range, epc_in,
        output read_data, flush, jump_en, jump_addr, int_pending, in_handler
    );
endinterface

// File: rtl/cp0_intc.sv
// Coprocessor-0 with vectored interrupt controller: Status/Cause/EPC, exception/eret/interrupt
// selection and pipeline flush / PC redirect for the MEM stage of the 5-stage pipeline.
module cp0_intc #(
    parameter int unsigned N_INT           = 2,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter logic [31:0] EXC_VECTOR      = 32'h0000_0008,
    parameter logic [31:0] INT_VECTOR_BASE = 32'h0000_000C,
    parameter int unsigned VEC_STRIDE      = 4
) (
    input  logic      clk,
    input  logic      reset,
    cp0_intc_if.slave bus
);

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_MFC0 = 2'b01,
        OP_MTC0 = 2'b10,
        OP_ERET = 2'b11
    } cp0_op_e;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_EXC,
        EV_ERET,
        EV_INT
    } event_e;

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    logic [SYNC_STAGES-1:0][N_INT-1:0] sync_q;
    logic [N_INT-1:0]                  hist_q;
    logic [N_INT-1:0]                  rise;

    logic             ie_q;
    logic             exl_q;
    logic [N_INT-1:0] im_q;
    logic [N_INT-1:0] ip_q;
    logic [4:0]       exc_code_q;
    logic [31:0]      epc_q;

    cp0_op_e          op;
    event_e           ev;
    logic             exc_req;
    logic [4:0]       exc_code_sel;
    logic [N_INT-1:0] pend;
    logic [N_INT-1:0] take_mask;
    logic [2:0]       chan;
    logic [31:0]      int_vector;
    logic             wr_en;
    logic             wr_status;
    logic             wr_cause;
    logic             wr_epc;
    logic [N_INT-1:0] cause_keep;
    logic [N_INT-1:0] taken_clr;
    logic [N_INT-1:0] ip_next;
    logic [31:0]      status_word;
    logic [31:0]      cause_word;

    assign op = cp0_op_e'(bus.operation);

    // Synchroniser chain plus one history flop per line; a rise is sync=1 while history=0.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            if (SYNC_STAGES > 1) begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], bus.irq_in};
            end else begin
                sync_q <= bus.irq_in;
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

    assign exc_req = bus.undefined | bus.overflow | bus.out_of_range;
    assign pend    = ip_q & im_q;

    // Isolate the lowest pending channel; two's-complement trick keeps only the least significant 1.
    assign take_mask = pend & (~pend + N_INT'(1));

    always_comb begin
        chan = '0;
        for (int unsigned i = 0; i < N_INT; i++) begin
            if (take_mask[i]) begin
                chan = 3'(i);
            end
        end
    end

    assign int_vector = INT_VECTOR_BASE + 32'(VEC_STRIDE) * {29'd0, chan};

    always_comb begin
        exc_code_sel = EXC_ADEL;
        if (bus.undefined) begin
            exc_code_sel = EXC_RI;
        end else if (bus.overflow) begin
            exc_code_sel = EXC_OV;
        end
    end

    // One event per cycle, exception > eret > interrupt; reset and stall suppress all of them.
    always_comb begin
        ev = EV_NONE;
        if (!reset && !bus.stall) begin
            if (exc_req) begin
                ev = EV_EXC;
            end else if (op == OP_ERET) begin
                ev = EV_ERET;
            end else if (ie_q && !exl_q && (pend != '0)) begin
                ev = EV_INT;
            end
        end
    end

    always_comb begin
        bus.flush     = 1'b0;
        bus.jump_en   = 1'b0;
        bus.jump_addr = '0;
        case (ev)
            EV_EXC: begin
                bus.flush     = 1'b1;
                bus.jump_en   = 1'b1;
                bus.jump_addr = EXC_VECTOR;
            end
            EV_ERET: begin
                bus.flush     = 1'b1;
                bus.jump_en   = 1'b1;
                bus.jump_addr = epc_q;
            end
            EV_INT: begin
                bus.flush     = 1'b1;
                bus.jump_en   = 1'b1;
                bus.jump_addr = int_vector;
            end
            default: begin
                bus.flush     = 1'b0;
                bus.jump_en   = 1'b0;
                bus.jump_addr = '0;
            end
        endcase
    end

    always_comb begin
        status_word              = '0;
        status_word[0]           = ie_q;
        status_word[1]           = exl_q;
        status_word[8 +: N_INT]  = im_q;
        cause_word               = '0;
        cause_word[6:2]          = exc_code_q;
        cause_word[8 +: N_INT]   = ip_q;
    end

    always_comb begin
        bus.read_data = '0;
        if (!reset && op == OP_MFC0) begin
            case (bus.read_addr)
                REG_STATUS: bus.read_data = status_word;
                REG_CAUSE:  bus.read_data = cause_word;
                REG_EPC:    bus.read_data = epc_q;
                default:    bus.read_data = '0;
            endcase
        end
    end

    // mtc0 still commits alongside a taken interrupt; only an exception in MEM squashes it.
    assign wr_en     = !reset && !bus.stall && (op == OP_MTC0) && !exc_req;
    assign wr_status = wr_en && (bus.write_addr == REG_STATUS);
    assign wr_cause  = wr_en && (bus.write_addr == REG_CAUSE);
    assign wr_epc    = wr_en && (bus.write_addr == REG_EPC);

    // Software may only clear IP; the trap acknowledges its channel; a fresh edge always wins.
    assign cause_keep = wr_cause ? bus.write_data[8 +: N_INT] : '1;
    assign taken_clr  = (ev == EV_INT) ? take_mask : '0;
    assign ip_next    = ((ip_q & cause_keep) & ~taken_clr) | rise;

    // Trap updates follow the mtc0 writes so they take precedence on shared fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            ie_q       <= 1'b0;
            exl_q      <= 1'b0;
            im_q       <= '0;
            ip_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            if (wr_status) begin
                ie_q  <= bus.write_data[0];
                exl_q <= bus.write_data[1];
                im_q  <= bus.write_data[8 +: N_INT];
            end
            if (wr_epc) begin
                epc_q <= bus.write_data;
            end
            case (ev)
                EV_EXC: begin
                    exc_code_q <= exc_code_sel;
                    exl_q      <= 1'b1;
                    if (!exl_q) begin
                        epc_q <= bus.epc_in;
                    end
                end
                EV_ERET: begin
                    exl_q <= 1'b0;
                end
                EV_INT: begin
                    exc_code_q <= EXC_INT;
                    exl_q      <= 1'b1;
                    epc_q      <= bus.epc_in;
                end
                default: begin
                end
            endcase
            ip_q <= ip_next;
        end
    end

    assign bus.int_pending = ip_q;
    assign bus.in_handler  = exl_q;

endmodule

// File: tb/tb_cp0_intc.sv
// Self-checking bench for cp0_intc: directed vector table, corner-case sequences and
// randomized traffic compared cycle by cycle against a behavioural model.
module tb_cp0_intc;
    localparam int unsigned N      = 2;
    localparam int unsigned S      = 2;
    localparam logic [31:0] EXC_V  = 32'h0000_0008;
    localparam logic [31:0] INT_B  = 32'h0000_000C;
    localparam int unsigned STRIDE = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cp0_intc_if #(.N_INT(N)) bus ();

    cp0_intc #(
        .N_INT          (N),
        .SYNC_STAGES    (S),
        .EXC_VECTOR     (EXC_V),
        .INT_VECTOR_BASE(INT_B),
        .VEC_STRIDE     (STRIDE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Architectural state of the model; m_samp[j] is irq_in as sampled j edges ago.
    bit         m_ie, m_exl;
    bit [N-1:0] m_im, m_ip;
    bit [4:0]   m_code;
    bit [31:0]  m_epc;
    bit [N-1:0] m_samp [S+1];

    int         e_kind;  // 0 none, 1 exception, 2 eret, 3 interrupt
    int         e_chan;
    bit [31:0]  e_jaddr, e_rdata;

    logic       obs_flush;
    logic [31:0] obs_jaddr, obs_rdata;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_im = '0; m_ip = '0; m_code = '0; m_epc = '0;
        for (int i = 0; i <= S; i++) m_samp[i] = '0;
    endtask

    task automatic model_predict();
        e_kind = 0; e_chan = -1; e_jaddr = '0; e_rdata = '0;
        if (!reset && !bus.stall) begin
            for (int k = N - 1; k >= 0; k--) if (m_ip[k] && m_im[k]) e_chan = k;
            if (bus.undefined || bus.overflow || bus.out_of_range) begin
                e_kind = 1; e_jaddr = EXC_V;
            end else if (bus.operation == 2'b11) begin
                e_kind = 2; e_jaddr = m_epc;
            end else if (m_ie && !m_exl && e_chan >= 0) begin
                e_kind = 3; e_jaddr = INT_B + 32'(e_chan * STRIDE);
            end
        end
        if (!reset && bus.operation == 2'b01) begin
            case (bus.read_addr)
                5'd12: e_rdata = 32'(m_ie) | (32'(m_exl) << 1) | (32'(m_im) << 8);
                5'd13: e_rdata = (32'(m_code) << 2) | (32'(m_ip) << 8);
                5'd14: e_rdata = m_epc;
                default: e_rdata = '0;
            endcase
        end
    endtask

    task automatic model_commit();
        bit [N-1:0] rise, keep;
        bit         exl0;
        if (reset) begin
            model_reset();
            return;
        end
        rise = m_samp[S-1] & ~m_samp[S];
        keep = '1;
        exl0 = m_exl;
        if (bus.operation == 2'b10 && !bus.stall && e_kind != 1) begin
            case (bus.write_addr)
                5'd12: begin
                    m_ie  = bus.write_data[0];
                    m_exl = bus.write_data[1];
                    m_im  = bus.write_data[8 +: N];
                end
                5'd13: keep = bus.write_data[8 +: N];
                5'd14: m_epc = bus.write_data;
                default: ;
            endcase
        end
        case (e_kind)
            1: begin
                if (bus.undefined) m_code = 5'd10;
                else if (bus.overflow) m_code = 5'd12;
                else m_code = 5'd4;
                if (!exl0) m_epc = bus.epc_in;
                m_exl = 1;
            end
            2: m_exl = 0;
            3: begin
                m_epc = bus.epc_in; m_code = 5'd0; m_exl = 1; m_ip[e_chan] = 1'b0;
            end
            default: ;
        endcase
        m_ip = (m_ip & keep) | rise;
        for (int i = S; i > 0; i--) m_samp[i] = m_samp[i-1];
        m_samp[0] = bus.irq_in;
    endtask

    // One clock: predict from current inputs, compare at the falling edge, advance the model.
    task automatic cycle();
        model_predict();
        @(negedge clk);
        obs_flush = bus.flush;
        obs_jaddr = bus.jump_addr;
        obs_rdata = bus.read_data;
        check32("flush",       32'(bus.flush),       32'(e_kind != 0));
        check32("jump_en",     32'(bus.jump_en),     32'(e_kind != 0));
        check32("jump_addr",   bus.jump_addr,        e_jaddr);
        check32("read_data",   bus.read_data,        e_rdata);
        check32("int_pending", 32'(bus.int_pending), 32'(m_ip));
        check32("in_handler",  32'(bus.in_handler),  32'(m_exl));
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] wd,
                         input logic [2:0] exc, input logic [31:0] epc, input logic stall_v);
        bus.operation  = op;
        bus.read_addr  = addr;
        bus.write_addr = addr;
        bus.write_data = wd;
        {bus.undefined, bus.overflow, bus.out_of_range} = exc;
        bus.epc_in     = epc;
        bus.stall      = stall_v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(2'b00, 5'd0, '0, 3'b000, '0, 1'b0);
            cycle();
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  exc;
        logic [31:0] epc;
        logic [N-1:0] irq;
        logic        e_flush;
        logic [31:0] e_jaddr;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int         n_flush;
        int         lat;
        logic [31:0] r;

        tbl[0]  = '{2'b10, 5'd12, 32'h301, 3'b000, 32'h0,   2'b00, 1'b0, 32'h0,   32'h0};
        tbl[1]  = '{2'b01, 5'd12, 32'h0,   3'b000, 32'h0,   2'b00, 1'b0, 32'h0,   32'h301};
        tbl[2]  = '{2'b00, 5'd0,  32'h0,   3'b000, 32'h0,   2'b10, 1'b0, 32'h0,   32'h0};
        tbl[3]  = '{2'b00, 5'd0,  32'h0,   3'b000, 32'h0,   2'b10, 1'b0, 32'h0,   32'h0};
        tbl[4]  = '{2'b00, 5'd0,  32'h0,   3'b000, 32'h0,   2'b10, 1'b0, 32'h0,   32'h0};
        tbl[5]  = '{2'b01, 5'd13, 32'h0,   3'b000, 32'h100, 2'b10, 1'b1, 32'h10,  32'h200};
        tbl[6]  = '{2'b01, 5'd14, 32'h0,   3'b000, 32'h0,   2'b10, 1'b0, 32'h0,   32'h100};
        tbl[7]  = '{2'b01, 5'd12, 32'h0,   3'b000, 32'h0,   2'b10, 1'b0, 32'h0,   32'h303};
        tbl[8]  = '{2'b01, 5'd13, 32'h0,   3'b000, 32'h0,   2'b10, 1'b0, 32'h0,   32'h0};
        tbl[9]  = '{2'b11, 5'd0,  32'h0,   3'b000, 32'h0,   2'b10, 1'b1, 32'h100, 32'h0};
        tbl[10] = '{2'b00, 5'd0,  32'h0,   3'b000, 32'h0,   2'b10, 1'b0, 32'h0,   32'h0};
        tbl[11] = '{2'b00, 5'd0,  32'h0,   3'b110, 32'h40,  2'b10, 1'b1, 32'h8,   32'h0};
        tbl[12] = '{2'b01, 5'd13, 32'h0,   3'b000, 32'h0,   2'b10, 1'b0, 32'h0,   32'h28};
        tbl[13] = '{2'b01, 5'd14, 32'h0,   3'b000, 32'h0,   2'b10, 1'b0, 32'h0,   32'h40};
        tbl[14] = '{2'b01, 5'd12, 32'h0,   3'b010, 32'h80,  2'b10, 1'b1, 32'h8,   32'h303};
        tbl[15] = '{2'b01, 5'd14, 32'h0,   3'b000, 32'h0,   2'b10, 1'b0, 32'h0,   32'h40};
        tbl[16] = '{2'b01, 5'd13, 32'h0,   3'b000, 32'h0,   2'b10, 1'b0, 32'h0,   32'h30};

        reset = 1'b1;
        bus.irq_in = '0;
        drive(2'b00, 5'd0, '0, 3'b000, '0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        cycle();
        reset = 1'b0;

        // Directed table: delivery latency, vectored trap, eret, exception priority and EPC guard.
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].exc, tbl[i].epc, 1'b0);
            bus.irq_in = tbl[i].irq;
            cycle();
            check32($sformatf("tbl%0d_flush", i), 32'(obs_flush), 32'(tbl[i].e_flush));
            check32($sformatf("tbl%0d_jaddr", i), obs_jaddr, tbl[i].e_jaddr);
            check32($sformatf("tbl%0d_rdata", i), obs_rdata, tbl[i].e_rdata);
        end

        // Simultaneous rise on both lines: channel 0 first, channel 1 right after eret.
        bus.irq_in = '0;
        drive(2'b11, 5'd0, '0, 3'b000, '0, 1'b0);
        cycle();
        idle(3);
        bus.irq_in = 2'b11;
        lat = -1;
        for (int i = 0; i < 8; i++) begin
            drive(2'b00, 5'd0, '0, 3'b000, 32'h200, 1'b0);
            cycle();
            if (obs_flush) begin
                lat = i;
                break;
            end
        end
        check32("dual_latency", 32'(lat), 32'd3);
        check32("dual_first_addr", obs_jaddr, 32'hC);
        drive(2'b11, 5'd0, '0, 3'b000, '0, 1'b0);
        cycle();
        check32("dual_eret_addr", obs_jaddr, 32'h200);
        drive(2'b00, 5'd0, '0, 3'b000, 32'h300, 1'b0);
        cycle();
        check32("dual_second_flush", 32'(obs_flush), 32'd1);
        check32("dual_second_addr", obs_jaddr, 32'h10);

        // Masked line stays pending; unmasking traps one cycle after the write; Cause write acks.
        drive(2'b11, 5'd0, '0, 3'b000, '0, 1'b0);
        cycle();
        drive(2'b10, 5'd12, 32'h001, 3'b000, '0, 1'b0);
        cycle();
        bus.irq_in = '0;
        idle(3);
        bus.irq_in = 2'b01;
        n_flush = 0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            n_flush += int'(obs_flush);
        end
        check32("masked_no_trap", 32'(n_flush), 32'd0);
        check32("masked_pending", 32'(bus.int_pending), 32'b01);
        drive(2'b10, 5'd12, 32'h101, 3'b000, '0, 1'b0);
        cycle();
        check32("unmask_write_cycle", 32'(obs_flush), 32'd0);
        drive(2'b00, 5'd0, '0, 3'b000, 32'h500, 1'b0);
        cycle();
        check32("unmask_trap_addr", obs_jaddr, 32'hC);
        bus.irq_in = '0;
        idle(3);
        bus.irq_in = 2'b10;
        idle(4);
        check32("ack_before", 32'(bus.int_pending), 32'b10);
        drive(2'b10, 5'd13, 32'h0, 3'b000, '0, 1'b0);
        cycle();
        check32("ack_after", 32'(bus.int_pending), 32'b00);

        // Stall holds the trap back while edge capture continues.
        drive(2'b11, 5'd0, '0, 3'b000, '0, 1'b0);
        cycle();
        drive(2'b10, 5'd12, 32'h301, 3'b000, '0, 1'b0);
        cycle();
        bus.irq_in = '0;
        idle(3);
        bus.irq_in = 2'b01;
        n_flush = 0;
        for (int i = 0; i < 5; i++) begin
            drive(2'b00, 5'd0, '0, 3'b000, '0, 1'b1);
            cycle();
            n_flush += int'(obs_flush);
        end
        check32("stall_no_flush", 32'(n_flush), 32'd0);
        drive(2'b00, 5'd0, '0, 3'b000, 32'h600, 1'b0);
        cycle();
        check32("stall_release_flush", 32'(obs_flush), 32'd1);
        check32("stall_release_addr", obs_jaddr, 32'hC);

        // Reset in the cycle an interrupt would be taken.
        drive(2'b11, 5'd0, '0, 3'b000, '0, 1'b0);
        cycle();
        bus.irq_in = '0;
        idle(3);
        bus.irq_in = 2'b10;
        idle(3);
        reset = 1'b1;
        drive(2'b00, 5'd0, '0, 3'b000, 32'h700, 1'b0);
        cycle();
        check32("reset_no_flush", 32'(obs_flush), 32'd0);
        reset = 1'b0;
        drive(2'b01, 5'd12, '0, 3'b000, '0, 1'b0);
        cycle();
        check32("reset_status", obs_rdata, 32'h0);
        check32("reset_pending", 32'(bus.int_pending), 32'h0);
        check32("reset_exl", 32'(bus.in_handler), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            r = $urandom;
            case ($urandom_range(0, 3))
                0: bus.read_addr = 5'd12;
                1: bus.read_addr = 5'd13;
                2: bus.read_addr = 5'd14;
                default: bus.read_addr = 5'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: bus.write_addr = 5'd12;
                1: bus.write_addr = 5'd13;
                2: bus.write_addr = 5'd14;
                default: bus.write_addr = 5'($urandom);
            endcase
            bus.operation    = 2'($urandom);
            bus.write_data   = $urandom;
            bus.undefined    = ($urandom_range(0, 19) == 0);
            bus.overflow     = ($urandom_range(0, 19) == 0);
            bus.out_of_range = ($urandom_range(0, 19) == 0);
            bus.epc_in       = $urandom;
            bus.stall        = ($urandom_range(0, 4) == 0);
            for (int k = 0; k < N; k++) begin
                if (r[k*4 +: 3] == 3'b000) bus.irq_in[k] = ~bus.irq_in[k];
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
- Parametrised coprocessor-0 and interrupt controller for the 5-stage MIPS pipeline. It sits beside the MEM stage.
- Handles N_INT asynchronous interrupt lines through synchronisers, rising-edge capture, pending latches, a per-line mask and fixed priority. It also handles MEM-stage exceptions, eret, and mfc0/mtc0 access to Status/Cause/EPC.
- Drives pipeline flush and PC redirect.
- Generalises the fixed two-line cp0 with vectored per-channel handlers, masking, a nesting guard (EXL) and stall awareness.

Parameters:
- N_INT, 2, number of interrupt lines (1..8)
- SYNC_STAGES, 2, synchroniser flops per line (>=2)
- EXC_VECTOR, 32'h0000_0008, handler address for all exceptions
- INT_VECTOR_BASE, 32'h0000_000C, handler address for channel 0
- VEC_STRIDE, 4, address spacing between channel handlers

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- irq_in  in  N_INT  raw asynchronous interrupt levels
- stall  in  1  pipeline frozen (cpu_en low); no trap/eret/write taken
- operation  in  2  MEM-stage cp0 op: 00 none, 01 mfc0, 10 mtc0, 11 eret
- read_addr  in  5  mfc0 rd
- read_data  out  32  mfc0 data
- write_addr  in  5  mtc0 rd
- write_data  in  32  mtc0 data
- undefined  in  1  MEM-stage reserved-instruction flag
- overflow  in  1  MEM-stage arithmetic overflow flag
- out_of_range  in  1  MEM-stage bad data address flag
- epc_in  in  32  resume address for the MEM-stage instruction
- flush  out  1  squash IF..MEM latches this cycle
- jump_en  out  1  redirect PC this cycle
- jump_addr  out  32  redirect target
- int_pending  out  N_INT  Cause.IP mirror
- in_handler  out  1  Status.EXL mirror

Behaviour:
- Registers, addressed by rd:
  - 12 Status: bit0 IE, bit1 EXL, bits[8+N_INT-1:8] IM; other bits read 0.
  - 13 Cause: bits[6:2] ExcCode, bits[8+N_INT-1:8] IP.
  - 14 EPC: 32 bits.
  - Any other address reads 0; writes to it are ignored.
- Reset: all registers, synchroniser flops and edge-history flops clear to 0. flush=0, jump_en=0, jump_addr=0, read_data=0. Reset asserted mid-handler clears EXL and drops all pending interrupts.
- Interrupt input path:
  - Each irq_in bit passes SYNC_STAGES flops, then one history flop.
  - A rise (sync=1, hist=0) sets IP[k] on that edge.
  - Latency from irq_in rise to IP visible is SYNC_STAGES+1 clocks.
  - Edge capture runs even while stall=1 or EXL=1.
  - A held-high line sets IP only once.
- Event selection is combinational from current register state. Only one event is taken per cycle, in priority order:
  1. Exception (any of undefined/overflow/out_of_range, stall=0).
     - ExcCode: undefined 10, else overflow 12, else out_of_range 4.
     - jump_addr=EXC_VECTOR.
     - EPC<=epc_in only if EXL=0 (no nested EPC overwrite). EXL<=1.
  2. eret (operation=11, stall=0): jump_addr=EPC, EXL<=0.
  3. Interrupt (IE=1, EXL=0, (IP&IM)!=0, stall=0).
     - Taken channel k is the lowest index.
     - jump_addr=INT_VECTOR_BASE+k*VEC_STRIDE (32-bit, wraps modulo 2^32).
     - EPC<=epc_in, ExcCode<=0, EXL<=1, IP[k]<=0.
- Outputs for a taken event: flush=1 and jump_en=1 in the same cycle (Mealy). Both drop the next cycle because the decision state has been updated. When no event is taken: flush=0, jump_en=0, jump_addr=0.
- mfc0 (operation=01): read_data is the combinational pre-edge value of read_addr. For every other operation read_data=0.
- mtc0 (operation=10, stall=0, no exception this cycle) writes on the clock edge.
  - IP bits written via Cause clear only: IP&=write_data bits, so software can acknowledge but never set.
  - ExcCode is read-only.
- Collisions:
  - Trap-induced field updates (EXL, EPC, IP[k]) override an mtc0 to the same field in the same cycle.
  - An edge-set of IP[k] overrides a clear in the same cycle.
  - An interrupt arriving during eret stays pending and is taken on the following eligible cycle.
  - The mtc0 of the MEM instruction still commits when an interrupt is taken (EPC=epc_in resumes after it).
- stall=1: no register writes except IP edge capture; no flush/jump_en; pending events are evaluated again once stall drops.

Test Plan:
- Reset, then irq_in[1] rises with IE=1, IM=2'b11, stall=0 → IP[1]=1 after 3 clocks; same cycle flush=jump_en=1, jump_addr=32'h10, EPC=epc_in, EXL=1, IP[1]=0.
- irq_in[0] and irq_in[1] rise together → channel 0 taken (jump_addr=32'hC). Then eret → jump_addr=EPC, EXL=0. Next cycle channel 1 taken (jump_addr=32'h10).
- undefined=1 and overflow=1 with epc_in=32'h40 → jump_addr=32'h8, ExcCode=10, EPC=32'h40. A second exception while EXL=1 leaves EPC=32'h40.
- IM=0 and IRQ rises → IP set, no trap. mtc0 Status IM=1 → trap the cycle after the write. mtc0 Cause with write_data=0 clears IP (acknowledge).
- stall=1 held 5 cycles while irq rises → no flush. Trap fires the first cycle stall=0.
- Reset asserted in the same cycle as an interrupt → no flush, all registers 0 next cycle.
